// File: rtl/alu_defs.sv
// Shared ALU definitions: 4-bit control codes emitted by the ALU control
// decoder and the execute-unit state encodings.
package alu_defs;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// One iteration per clock after start; 'done' and 'product' are combinational
// during the final iteration so the caller can register the product on that
// same edge.
module alu_shift_add_mul #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_next;

  // Accumulator value after the current iteration
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  assign product = acc_next;
  assign done    = busy && (count == CW'(ITERS - 1));

  // Load operands on start, then shift/add once per cycle until the last iteration
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and registered result/flags.
// Optional feature macro: ALU_MUL_EN enables the 32-cycle iterative multiplier
// for code 1000; without it, code 1000 executes as ADD in one cycle.
module alu_exec_unit
  import alu_defs::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int MSB = WIDTH - 1;

  // The multiplier iterates once per operand bit, so its count is tied to WIDTH
  if (MUL_CYCLES != WIDTH) begin : g_cfg_check
    $error("alu_exec_unit: MUL_CYCLES must equal WIDTH");
  end

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] op_result;
  logic             op_overflow;
  logic             slt_bit;
  logic             accept;
  logic             consume;

  assign sum     = a + b;
  assign diff    = a - b;
  assign consume = out_valid && out_ready;
  assign accept  = in_valid && in_ready;

  // Signed less-than robust to subtraction overflow: differing signs decide directly
  assign slt_bit = (a[MSB] != b[MSB]) ? a[MSB] : diff[MSB];

  // Single-cycle operation datapath; unknown codes fall through to ADD
  always_comb begin
    op_result   = sum;
    op_overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    case (alu_ctrl)
      ALU_AND: begin
        op_result   = a & b;
        op_overflow = 1'b0;
      end
      ALU_OR: begin
        op_result   = a | b;
        op_overflow = 1'b0;
      end
      ALU_XOR: begin
        op_result   = a ^ b;
        op_overflow = 1'b0;
      end
      ALU_SUB: begin
        op_result   = diff;
        op_overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      ALU_SLT: begin
        op_result   = {{(WIDTH-1){1'b0}}, slt_bit};
        op_overflow = 1'b0;
      end
      default: begin
        op_result   = sum;
        op_overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
    endcase
  end

`ifdef ALU_MUL_EN

  alu_state_t       state;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign mul_start = accept && (alu_ctrl == ALU_MUL);
  assign in_ready  = (state == IDLE) && !mul_busy && (!out_valid || out_ready);

  alu_shift_add_mul #(
    .WIDTH (WIDTH),
    .ITERS (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM: single-cycle ops load immediately, MUL parks in BUSY until done
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            state     <= BUSY;
            out_valid <= 1'b0;
          end else if (accept) begin
            result    <= op_result;
            zero      <= (op_result == '0);
            overflow  <= op_overflow;
            out_valid <= 1'b1;
          end else if (consume) begin
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (mul_done) begin
            result    <= mul_product;
            zero      <= (mul_product == '0);
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  assign in_ready = !out_valid || out_ready;

  // Result register: load on accept, drop valid once consumed with no new accept
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
    end else if (accept) begin
      result    <= op_result;
      zero      <= (op_result == '0);
      overflow  <= op_overflow;
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit with hand-computed expected values.
// Build with +define+ALU_MUL_EN to exercise the iterative multiplier.
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one single-cycle op with out_ready=1 and check the registered outputs
  task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [31:0] opa,
                        input logic [31:0] opb, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_ovf);
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = ctrl;
    a        = opa;
    b        = opb;
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_val({tag, "_result"}, 64'(result), 64'(exp_res));
    check_val({tag, "_zero"}, 64'(zero), 64'(exp_zero));
    check_val({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    $display("op %s ctrl=%b a=0x%08h b=0x%08h -> result=0x%08h zero=%0b ovf=%0b",
             tag, ctrl, opa, opb, result, zero, overflow);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'b0000;
    a         = '0;
    b         = '0;

    // Reset held for two edges, then released
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_zero", 64'(zero), 64'd1);
    check_val("rst_ovf", 64'(overflow), 64'd0);
    check_val("rst_result", 64'(result), 64'd0);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    $display("reset released: out_valid=%0b zero=%0b in_ready=%0b", out_valid, zero, in_ready);

    out_ready = 1'b1;
    run_op("add_5_7",     4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0);
    run_op("sub_ovf",     4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1);
    run_op("sub_eq",      4'b0110, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0);
    run_op("sub_neg",     4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("slt_min_1",   4'b0111, 32'h80000000, 32'd1,        32'd1,        1'b0, 1'b0);
    run_op("slt_1_min",   4'b0111, 32'd1,        32'h80000000, 32'd0,        1'b1, 1'b0);
    run_op("slt_max_m1",  4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0);
    run_op("slt_m1_max",  4'b0111, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1,        1'b0, 1'b0);
    run_op("xor",         4'b1100, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 1'b0);
    run_op("and",         4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0);
    run_op("or",          4'b0001, 32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0);
    run_op("add_ovf",     4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1);
    run_op("add_wrap",    4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0);
    run_op("undef_1111",  4'b1111, 32'd3,        32'd4,        32'd7,        1'b0, 1'b0);
    run_op("undef_0011",  4'b0011, 32'h80000000, 32'h80000000, 32'd0,        1'b1, 1'b1);
`ifndef ALU_MUL_EN
    run_op("mul_as_add",  4'b1000, 32'd3,        32'd4,        32'd7,        1'b0, 1'b0);
`endif

    // Backpressure: AND result held while downstream stalls, OR waits at the input
    run_op("bp_and",      4'b0000, 32'h12345678, 32'h0F0F0F0F, 32'h02040608, 1'b0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0001;
    a         = 32'h00F0_0000;
    b         = 32'h0000_000F;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      check_val($sformatf("bp_hold_result_%0d", i), 64'(result), 64'h02040608);
      check_val($sformatf("bp_hold_valid_%0d", i), 64'(out_valid), 64'd1);
      $display("stall cycle %0d: result=0x%08h in_ready=%0b", i, result, in_ready);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("bp_or_result", 64'(result), 64'h00F0000F);
    check_val("bp_or_valid", 64'(out_valid), 64'd1);
    $display("released: OR result=0x%08h", result);
    @(posedge clk);
    #1;
    check_val("drain_valid", 64'(out_valid), 64'd0);
    $display("drained: out_valid=%0b", out_valid);

`ifdef ALU_MUL_EN
    // Multiply: accept at edge N, result visible after edge N+32
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'b1000;
    a        = 32'd1234;
    b        = 32'd5678;
    check_val("mul_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i < 32; i++) begin
      check_val($sformatf("mul_busy_ready_%0d", i), 64'(in_ready), 64'd0);
      check_val($sformatf("mul_busy_valid_%0d", i), 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    check_val("mul_busy_ready_32", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check_val("mul_valid", 64'(out_valid), 64'd1);
    check_val("mul_result", 64'(result), 64'd7006652);
    check_val("mul_zero", 64'(zero), 64'd0);
    check_val("mul_ovf", 64'(overflow), 64'd0);
    $display("op mul a=1234 b=5678 -> result=%0d", result);

    // Reset during the multiply aborts it
    @(negedge clk);
    in_valid = 1'b1;
    alu_ctrl = 4'b1000;
    a        = 32'd7;
    b        = 32'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        check_val($sformatf("mul_abort_cycle_%0d", i), {62'd0, out_valid, in_ready}, 64'd1);
      end
    end
    check_val("mul_abort_valid", 64'(out_valid), 64'd0);
    check_val("mul_abort_in_ready", 64'(in_ready), 64'd1);
    $display("mul aborted by reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    out_ready = 1'b1;
    run_op("post_abort_add", 4'b0010, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
